// File: rtl/ft245_dac_player.sv
// Sample player behind an FT245 byte link: loads 12-bit samples into on-chip RAM,
// acknowledges a complete load, and plays RAM in a loop to a DAC at a programmable rate.
module ft245_dac_player #(
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] SAMPLE_LAST = 10'd1023,
  parameter logic [7:0]            ACK_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_DONE,
  input  logic [7:0]  RX_DATA,
  input  logic        TX_VALID,
  input  logic        TX_DONE,
  output logic        TXEN,
  output logic [7:0]  TX_DATA,
  output logic        DAC_CLK,
  output logic [11:0] DAC_DATA,
  output logic        BUSY
);

  localparam logic [3:0] CMD_LOAD   = 4'd3;
  localparam logic [3:0] CMD_SETDIV = 4'd4;
  localparam logic [3:0] CMD_PLAY   = 4'd5;
  localparam logic [3:0] CMD_STOP   = 4'd6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_L,
    LOAD_H,
    ACK_WAIT,
    ACK_DONE,
    PLAY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]            div_cnt_q, div_cnt_d;
  logic [3:0]            divider_q, divider_d;
  logic [7:0]            low_byte_q, low_byte_d;
  logic                  txen_q, txen_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  dac_clk_q, dac_clk_d;
  logic [11:0]           dac_data_q, dac_data_d;

  logic [11:0]           ram_mem [0:(1 << ADDR_WIDTH) - 1];
  logic [11:0]           ram_rdata;
  logic                  ram_we;
  logic [11:0]           ram_wdata;

  logic [3:0]            cmd;
  logic [3:0]            new_div;

  assign cmd     = RX_DATA[3:0];
  assign new_div = RX_DATA[7:4];

  // Read port runs every cycle so RAM[rd_addr] is already waiting at the next falling DAC edge.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_mem[wr_addr_q] <= ram_wdata;
    end
    ram_rdata <= ram_mem[rd_addr_q];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      div_cnt_q  <= '0;
      divider_q  <= 4'd3;
      low_byte_q <= '0;
      txen_q     <= 1'b0;
      tx_data_q  <= '0;
      dac_clk_q  <= 1'b0;
      dac_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      div_cnt_q  <= div_cnt_d;
      divider_q  <= divider_d;
      low_byte_q <= low_byte_d;
      txen_q     <= txen_d;
      tx_data_q  <= tx_data_d;
      dac_clk_q  <= dac_clk_d;
      dac_data_q <= dac_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    div_cnt_d  = div_cnt_q;
    divider_d  = divider_q;
    low_byte_d = low_byte_q;
    txen_d     = 1'b0;
    tx_data_d  = tx_data_q;
    dac_clk_d  = 1'b0;
    dac_data_d = dac_data_q;
    ram_we     = 1'b0;
    ram_wdata  = {RX_DATA[3:0], low_byte_q};

    unique case (state_q)
      IDLE: begin
        if (RX_DONE) begin
          case (cmd)
            CMD_LOAD: begin
              wr_addr_d = '0;
              state_d   = LOAD_L;
            end
            CMD_PLAY: begin
              rd_addr_d = '0;
              div_cnt_d = '0;
              state_d   = PLAY;
            end
            CMD_SETDIV: divider_d = new_div;
            default: ;
          endcase
        end
      end

      LOAD_L: begin
        if (RX_DONE) begin
          low_byte_d = RX_DATA;
          state_d    = LOAD_H;
        end
      end

      LOAD_H: begin
        if (RX_DONE) begin
          ram_we = 1'b1;
          if (wr_addr_q == SAMPLE_LAST) begin
            state_d = ACK_WAIT;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            state_d   = LOAD_L;
          end
        end
      end

      ACK_WAIT: begin
        if (!TX_VALID) begin
          txen_d    = 1'b1;
          tx_data_d = ACK_BYTE;
          state_d   = ACK_DONE;
        end
      end

      ACK_DONE: begin
        if (TX_DONE) begin
          state_d = IDLE;
        end
      end

      PLAY: begin
        dac_clk_d = dac_clk_q;
        // >= rather than == so a counter left above a freshly lowered divider still terminates.
        if (div_cnt_q >= divider_q) begin
          div_cnt_d = '0;
          dac_clk_d = ~dac_clk_q;
          if (dac_clk_q) begin
            dac_data_d = ram_rdata;
            rd_addr_d  = (rd_addr_q == SAMPLE_LAST) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + 4'd1;
        end

        if (RX_DONE) begin
          if (cmd == CMD_STOP) begin
            state_d    = IDLE;
            dac_clk_d  = 1'b0;
            dac_data_d = dac_data_q;
            rd_addr_d  = rd_addr_q;
            div_cnt_d  = '0;
          end else if (cmd == CMD_SETDIV) begin
            divider_d = new_div;
            if (new_div < div_cnt_q) begin
              div_cnt_d = '0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign TXEN     = txen_q;
  assign TX_DATA  = tx_data_q;
  assign DAC_CLK  = dac_clk_q;
  assign DAC_DATA = dac_data_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: doc/ft245_dac_player.md
FT245_DAC_PLAYER -- requirements
Module: ft245_dac_player

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, sample RAM address width.
REQ-002 SHALL have parameter SAMPLE_LAST, default 10'd1023, the last sample address loaded and played.
REQ-003 SHALL have parameter ACK_BYTE, default 8'hA5, the byte returned after a complete load.
REQ-004 SHALL have port CLK, input, 1 bit, system clock (100 MHz).
REQ-005 SHALL have port RST, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port RX_DONE, input, 1 bit, one-cycle pulse from the FT245 wrapper marking a received byte.
REQ-007 SHALL have port RX_DATA, input, 8 bits, received byte, valid while RX_DONE is high.
REQ-008 SHALL have port TX_VALID, input, 1 bit, FT245 wrapper busy or buffer full when high.
REQ-009 SHALL have port TX_DONE, input, 1 bit, one-cycle pulse marking that a transmit byte has completed.
REQ-010 SHALL have port TXEN, output, 1 bit, one-cycle transmit request.
REQ-011 SHALL have port TX_DATA, output, 8 bits, transmit byte.
REQ-012 SHALL have port DAC_CLK, output, 1 bit, DAC sample clock.
REQ-013 SHALL have port DAC_DATA, output, 12 bits, DAC sample.
REQ-014 SHALL have port BUSY, output, 1 bit, high in any state other than IDLE.

Function
REQ-015 SHALL decode commands only in IDLE and PLAY, from RX_DATA[3:0] on RX_DONE: 4'd3 LOAD, 4'd5 PLAY, 4'd6 STOP, 4'd4 SETDIV.
REQ-016 SHALL implement the states IDLE, LOAD_L, LOAD_H, ACK_WAIT, ACK_DONE and PLAY.
REQ-017 SHALL, in IDLE, handle commands as follows: LOAD clears wr_addr to 0 and moves to LOAD_L; PLAY clears rd_addr and div_cnt and moves to PLAY; SETDIV loads divider[3:0] from RX_DATA[7:4]; STOP and undefined codes are ignored.
REQ-018 SHALL, in LOAD_L, latch RX_DATA as the low byte on RX_DONE and move to LOAD_H.
REQ-019 SHALL, in LOAD_H, write {RX_DATA[3:0], low_byte} into RAM[wr_addr] on RX_DONE (upper nibble discarded). It then moves to ACK_WAIT if wr_addr == SAMPLE_LAST; otherwise it increments wr_addr and returns to LOAD_L.
REQ-020 SHALL treat every byte in LOAD_L/LOAD_H as data, never as a command.
REQ-021 SHALL, in ACK_WAIT, when TX_VALID is low, drive TXEN=1 for exactly one cycle with TX_DATA=ACK_BYTE and move to ACK_DONE; while TX_VALID is high it waits without a timeout.
REQ-022 SHALL, in ACK_DONE, move to IDLE on TX_DONE.
REQ-023 SHALL, in PLAY, count div_cnt from 0 to divider; at terminal count it toggles DAC_CLK and clears div_cnt, giving F(DAC_CLK) = CLK/(2*(divider+1)).
REQ-024 SHALL update DAC_DATA from RAM[rd_addr] in the same cycle that DAC_CLK toggles 1->0, then advance rd_addr; rd_addr wraps from SAMPLE_LAST to 0 and playback loops indefinitely.
REQ-025 SHALL prefetch through a synchronous RAM read so that the first falling DAC_CLK edge after entering PLAY outputs RAM[0].
REQ-026 SHALL, in PLAY, handle RX_DONE with STOP by moving to IDLE next cycle with DAC_CLK forced to 0 and DAC_DATA held; SETDIV updates divider, effective at the next terminal count; LOAD and PLAY are ignored.
REQ-027 SHALL ensure that a SETDIV which lowers divider below the current div_cnt clears div_cnt rather than wrapping.
REQ-028 SHALL keep DAC_CLK low and DAC_DATA unchanged outside PLAY.
REQ-029 SHALL allow PLAY with no prior LOAD, playing whatever RAM holds.

Reset
REQ-030 SHALL, on RST low, immediately set state=IDLE, TXEN=0, TX_DATA=0, DAC_CLK=0, DAC_DATA=0, BUSY=0, divider=3, wr_addr=0, rd_addr=0, div_cnt=0 and low_byte=0.
REQ-031 SHALL leave RAM contents unchanged by reset; a reset mid-load abandons the load with no ACK sent.

Verification
REQ-032 SHALL be covered by this bench scenario: send 0x03, then 2048 bytes where sample k = k, low byte first -> one TXEN with TX_DATA=0xA5 after the last byte; no TXEN earlier.
REQ-033 SHALL be covered by this bench scenario: after load, send 0x05 with default divider 3 -> DAC_CLK period 8 CLK cycles; DAC_DATA sequence 0,1,2...1023,0,1 at successive falling edges.
REQ-034 SHALL be covered by this bench scenario: send 0x14 (divider 1) in IDLE, then 0x05 -> DAC_CLK period 4 cycles; send 0x06 -> DAC_CLK=0 and DAC_DATA frozen within 2 cycles, BUSY=0.
REQ-035 SHALL be covered by this bench scenario: hold TX_VALID=1 for 50 cycles at load end -> TXEN stays 0, then pulses once within 1 cycle of TX_VALID falling.
REQ-036 SHALL be covered by this bench scenario: mid-load, a data byte 0x05 arrives -> stored as data with no playback; assert RST after 100 bytes -> IDLE, no ACK; a new 0x03 restarts at wr_addr 0.
REQ-037 SHALL be covered by this bench scenario: 0x04 with RX_DATA[7:4]=0 during PLAY at div_cnt=2 -> div_cnt cleared and DAC_CLK period 2 cycles thereafter.
